// File: rtl/dm_access_ctrl_if.sv
// Bus bundle for dm_access_ctrl: transfer request, producer/consumer streams and DM port.
// The master modport is the requester/memory side; the slave modport is the controller.
interface dm_access_ctrl_if #(
    parameter int unsigned DMA_SIZE = 17,
    parameter int unsigned DMD_SIZE = 16,
    parameter int unsigned CNT_SIZE = 8
);
    logic                start;
    logic                wr_mode;
    logic [DMA_SIZE-1:0] base_add;
    logic [DMA_SIZE-1:0] modify;
    logic [CNT_SIZE-1:0] count;
    logic [DMA_SIZE-1:0] buf_len;
    logic [DMD_SIZE-1:0] wr_data;
    logic                wr_valid;
    logic                wr_ready;
    logic [DMD_SIZE-1:0] rd_data;
    logic                rd_valid;
    logic                busy;
    logic                done;
    logic                ps_dm_cslt;
    logic                ps_dm_wrb;
    logic [DMA_SIZE-1:0] dg_dm_add;
    logic [DMD_SIZE-1:0] bc_dt;
    logic [DMD_SIZE-1:0] dm_bc_dt;

    modport master (
        output start, wr_mode, base_add, modify, count, buf_len, wr_data, wr_valid, dm_bc_dt,
        input  wr_ready, rd_data, rd_valid, busy, done, ps_dm_cslt, ps_dm_wrb, dg_dm_add, bc_dt
    );

    modport slave (
        input  start, wr_mode, base_add, modify, count, buf_len, wr_data, wr_valid, dm_bc_dt,
        output wr_ready, rd_data, rd_valid, busy, done, ps_dm_cslt, ps_dm_wrb, dg_dm_add, bc_dt
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// Data-memory transfer sequencer: issues read/write bursts with post-modify addressing.
// Define DAG_CIRC_EN to enable circular-buffer address wrapping (buf_len != 0).
module dm_access_ctrl #(
    parameter int unsigned DMA_SIZE = 17,
    parameter int unsigned DMD_SIZE = 16,
    parameter int unsigned CNT_SIZE = 8
) (
    input  logic            clk,
    input  logic            reset,
    dm_access_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TAIL = 2'd2
    } state_e;

    state_e              state_q;
    logic                wr_mode_q;
    logic [DMA_SIZE-1:0] base_q;
    logic [DMA_SIZE-1:0] modify_q;
    logic [DMA_SIZE-1:0] addr_q;
    logic [DMA_SIZE-1:0] last_add_q;
    logic [CNT_SIZE-1:0] rem_q;
    logic [DMD_SIZE-1:0] bc_dt_q;
    logic [DMD_SIZE-1:0] rd_last_q;
    logic                busy_q;
    logic                done_q;
    logic                wr_ready_q;
    logic                rd_valid_q;

    logic                access_c;
    logic [DMA_SIZE-1:0] addr_next_c;

    // A write access happens in the very cycle the producer offers a word.
    assign access_c = (state_q == RUN) && (!wr_mode_q || bus.wr_valid);

`ifdef DAG_CIRC_EN
    localparam int unsigned OFS_W = DMA_SIZE + 2;

    logic [DMA_SIZE-1:0]     buf_len_q;
    logic [DMA_SIZE-1:0]     rel_c;
    logic signed [OFS_W-1:0] ofs_c;
    logic signed [OFS_W-1:0] len_c;

    // Wrap on the offset from base so buffers straddling 2^DMA_SIZE still work.
    always_comb begin
        rel_c       = addr_q - base_q;
        len_c       = signed'(OFS_W'(buf_len_q));
        ofs_c       = signed'(OFS_W'(rel_c)) + OFS_W'(signed'(modify_q));
        addr_next_c = addr_q + modify_q;
        if (buf_len_q != '0) begin
            if (ofs_c >= len_c) begin
                ofs_c = ofs_c - len_c;
            end else if (ofs_c[OFS_W-1]) begin
                ofs_c = ofs_c + len_c;
            end
            addr_next_c = base_q + DMA_SIZE'(ofs_c);
        end
    end
`else
    logic unused_buf_len;
    assign unused_buf_len = ^bus.buf_len;
    assign addr_next_c    = addr_q + modify_q;
`endif

    assign bus.ps_dm_cslt = access_c;
    assign bus.ps_dm_wrb  = access_c && wr_mode_q;
    assign bus.dg_dm_add  = access_c ? addr_q : last_add_q;
    assign bus.bc_dt      = bc_dt_q;
    assign bus.rd_data    = rd_valid_q ? bus.dm_bc_dt : rd_last_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.wr_ready   = wr_ready_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_mode_q  <= 1'b0;
            base_q     <= '0;
            modify_q   <= '0;
            addr_q     <= '0;
            last_add_q <= '0;
            rem_q      <= '0;
            bc_dt_q    <= '0;
            rd_last_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
`ifdef DAG_CIRC_EN
            buf_len_q  <= '0;
`endif
        end else begin
            done_q     <= 1'b0;
            rd_valid_q <= access_c && !wr_mode_q;
            if (rd_valid_q) begin
                rd_last_q <= bus.dm_bc_dt;
            end
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.count != '0) begin
                            state_q    <= RUN;
                            wr_mode_q  <= bus.wr_mode;
                            base_q     <= bus.base_add;
                            modify_q   <= bus.modify;
                            addr_q     <= bus.base_add;
                            rem_q      <= bus.count;
                            busy_q     <= 1'b1;
                            wr_ready_q <= bus.wr_mode;
`ifdef DAG_CIRC_EN
                            buf_len_q  <= bus.buf_len;
`endif
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (access_c) begin
                        last_add_q <= addr_q;
                        addr_q     <= addr_next_c;
                        rem_q      <= rem_q - CNT_SIZE'(1);
                        if (wr_mode_q) begin
                            bc_dt_q <= bus.wr_data;
                        end
                        // Last access: write data / read data land during TAIL.
                        if (rem_q == CNT_SIZE'(1)) begin
                            state_q    <= TAIL;
                            done_q     <= 1'b1;
                            wr_ready_q <= 1'b0;
                        end
                    end
                end
                TAIL: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/dm_access_ctrl.md
DM_ACCESS_CTRL -- requirements
Module: dm_access_ctrl

Interface
REQ-001 SHALL have parameter DMA_SIZE, default 17: DM address width.
REQ-002 SHALL have parameter DMD_SIZE, default 16: DM data width.
REQ-003 SHALL have parameter CNT_SIZE, default 8: transfer count width.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1: one-cycle transfer request, sampled only in IDLE.
REQ-007 SHALL have port wr_mode  input  1: 1 = write transfer, 0 = read transfer; sampled with start.
REQ-008 SHALL have port base_add  input  DMA_SIZE: first address; sampled with start.
REQ-009 SHALL have port modify  input  DMA_SIZE: two's-complement post-modify step; sampled with start.
REQ-010 SHALL have port count  input  CNT_SIZE: number of words; sampled with start.
REQ-011 SHALL have port buf_len  input  DMA_SIZE: circular buffer length, 0 = linear; sampled with start.
REQ-012 SHALL have port wr_data  input  DMD_SIZE: write word from the producer.
REQ-013 SHALL have port wr_valid  input  1: wr_data valid.
REQ-014 SHALL have port wr_ready  output  1: word accepted when wr_valid and wr_ready are both high.
REQ-015 SHALL have port rd_data  output  DMD_SIZE: read word to the consumer.
REQ-016 SHALL have port rd_valid  output  1: one-cycle qualifier for rd_data; no backpressure.
REQ-017 SHALL have port busy  output  1: high whenever the FSM is outside IDLE.
REQ-018 SHALL have port done  output  1: one-cycle pulse on transfer completion.
REQ-019 SHALL have port ps_dm_cslt  output  1: DM chip select for the current cycle.
REQ-020 SHALL have port ps_dm_wrb  output  1: DM write strobe (1 = write, 0 = read).
REQ-021 SHALL have port dg_dm_add  output  DMA_SIZE: DM address.
REQ-022 SHALL have port bc_dt  output  DMD_SIZE: DM write data.
REQ-023 SHALL have port dm_bc_dt  input  DMD_SIZE: DM read data, registered by the memory.

Function
REQ-024 SHALL implement FSM states IDLE, RUN and TAIL.
REQ-025 IDLE: start with count!=0 SHALL latch all sampled inputs, load addr=base_add and remaining=count, and go to RUN.
REQ-026 IDLE: start with count==0 SHALL pulse done in the following cycle and stay in IDLE.
REQ-027 start outside IDLE SHALL be ignored.
REQ-028 RUN read: SHALL issue one access every cycle (ps_dm_cslt=1, ps_dm_wrb=0, dg_dm_add=addr).
REQ-029 RUN write: wr_ready SHALL be 1; an access (ps_dm_cslt=1, ps_dm_wrb=1) SHALL be issued only in cycles where wr_valid=1; idle cycles SHALL drive ps_dm_cslt=0.
REQ-030 Write data SHALL be registered and driven on bc_dt in the cycle after its address phase, matching the DM's execute+1 write.
REQ-031 Read data SHALL be captured from dm_bc_dt in the cycle after its address phase and presented on rd_data with rd_valid=1, i.e. 1 cycle of latency.
REQ-032 After each access, addr SHALL become addr+modify modulo 2^DMA_SIZE, and remaining SHALL decrement.
REQ-033 The final access SHALL move the FSM to TAIL; in TAIL, bc_dt or rd_data SHALL complete, done SHALL pulse and busy SHALL still be high; the next state SHALL be IDLE.
REQ-034 Outside access cycles, ps_dm_cslt SHALL be 0 and dg_dm_add and bc_dt SHALL hold their last values; wr_ready SHALL be 0 outside RUN or in read mode.

Reset
REQ-035 reset SHALL force IDLE and drive the outputs low: busy, done, wr_ready, rd_valid, ps_dm_cslt, ps_dm_wrb, dg_dm_add, bc_dt and rd_data all = 0.
REQ-036 reset mid-transfer SHALL abandon the transfer with no done pulse, and SHALL issue no further access after reset deasserts.

Configuration
REQ-037 Macro DAG_CIRC_EN, when defined and buf_len!=0, SHALL wrap the next address within [base_add, base_add+buf_len-1]: subtract buf_len if next >= base_add+buf_len, add buf_len if next < base_add; |modify| <= buf_len is required of the user.
REQ-038 Without DAG_CIRC_EN, buf_len SHALL be ignored and addressing SHALL always be linear modulo 2^DMA_SIZE.

Verification
REQ-039 Read: base=0x00010, modify=1, count=4 -> cslt high 4 cycles with addresses 0x10-0x13, rd_valid on 4 consecutive cycles each 1 cycle later, done once.
REQ-040 Write with gaps: count=3, wr_valid pattern 1,0,1,1, data 0xA1,0xA2,0xA3 -> cslt pattern 1,0,1,1 and each bc_dt equals its word 1 cycle after its address.
REQ-041 Circular (DAG_CIRC_EN): base=0x20, modify=3, buf_len=5, count=4 read -> addresses 0x20, 0x23, 0x21, 0x24.
REQ-042 Negative modify, linear: base=0x00001, modify=-2, count=2 -> addresses 0x00001, 0x1FFFF.
REQ-043 count=0 start -> no cslt and one done pulse; start while busy -> ignored.
REQ-044 reset asserted in the third RUN cycle -> all outputs 0 at once, no done, and idle with no DM traffic after release.
